// File: rtl/dram_axi_arbiter.sv
// Two-port AXI4 arbiter in front of the single-outstanding DRAM controller.
// Whole transactions are granted round-robin; WLAST is regenerated from AWLEN.
module dram_axi_arbiter #(
  parameter int AXI4_ID_WIDTH = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // port 0 (CPU)
  input  logic [AXI4_ID_WIDTH-1:0] s0_awid,
  input  logic [ADDR_WIDTH-1:0]    s0_awaddr,
  input  logic [7:0]               s0_awlen,
  input  logic [2:0]               s0_awsize,
  input  logic [1:0]               s0_awburst,
  input  logic                     s0_awvalid,
  output logic                     s0_awready,
  input  logic [DATA_WIDTH-1:0]    s0_wdata,
  input  logic [DATA_WIDTH/8-1:0]  s0_wstrb,
  input  logic                     s0_wlast,
  input  logic                     s0_wvalid,
  output logic                     s0_wready,
  output logic [AXI4_ID_WIDTH-1:0] s0_bid,
  output logic [1:0]               s0_bresp,
  output logic                     s0_bvalid,
  input  logic                     s0_bready,
  input  logic [AXI4_ID_WIDTH-1:0] s0_arid,
  input  logic [ADDR_WIDTH-1:0]    s0_araddr,
  input  logic [7:0]               s0_arlen,
  input  logic [2:0]               s0_arsize,
  input  logic [1:0]               s0_arburst,
  input  logic                     s0_arvalid,
  output logic                     s0_arready,
  output logic [AXI4_ID_WIDTH-1:0] s0_rid,
  output logic [DATA_WIDTH-1:0]    s0_rdata,
  output logic [1:0]               s0_rresp,
  output logic                     s0_rlast,
  output logic                     s0_rvalid,
  input  logic                     s0_rready,
  // port 1 (DMA)
  input  logic [AXI4_ID_WIDTH-1:0] s1_awid,
  input  logic [ADDR_WIDTH-1:0]    s1_awaddr,
  input  logic [7:0]               s1_awlen,
  input  logic [2:0]               s1_awsize,
  input  logic [1:0]               s1_awburst,
  input  logic                     s1_awvalid,
  output logic                     s1_awready,
  input  logic [DATA_WIDTH-1:0]    s1_wdata,
  input  logic [DATA_WIDTH/8-1:0]  s1_wstrb,
  input  logic                     s1_wlast,
  input  logic                     s1_wvalid,
  output logic                     s1_wready,
  output logic [AXI4_ID_WIDTH-1:0] s1_bid,
  output logic [1:0]               s1_bresp,
  output logic                     s1_bvalid,
  input  logic                     s1_bready,
  input  logic [AXI4_ID_WIDTH-1:0] s1_arid,
  input  logic [ADDR_WIDTH-1:0]    s1_araddr,
  input  logic [7:0]               s1_arlen,
  input  logic [2:0]               s1_arsize,
  input  logic [1:0]               s1_arburst,
  input  logic                     s1_arvalid,
  output logic                     s1_arready,
  output logic [AXI4_ID_WIDTH-1:0] s1_rid,
  output logic [DATA_WIDTH-1:0]    s1_rdata,
  output logic [1:0]               s1_rresp,
  output logic                     s1_rlast,
  output logic                     s1_rvalid,
  input  logic                     s1_rready,
  // downstream toward dram_controller
  output logic [AXI4_ID_WIDTH-1:0] m_awid,
  output logic [ADDR_WIDTH-1:0]    m_awaddr,
  output logic [7:0]               m_awlen,
  output logic [2:0]               m_awsize,
  output logic [1:0]               m_awburst,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [DATA_WIDTH-1:0]    m_wdata,
  output logic [DATA_WIDTH/8-1:0]  m_wstrb,
  output logic                     m_wlast,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  input  logic [AXI4_ID_WIDTH-1:0] m_bid,
  input  logic [1:0]               m_bresp,
  input  logic                     m_bvalid,
  output logic                     m_bready,
  output logic [AXI4_ID_WIDTH-1:0] m_arid,
  output logic [ADDR_WIDTH-1:0]    m_araddr,
  output logic [7:0]               m_arlen,
  output logic [2:0]               m_arsize,
  output logic [1:0]               m_arburst,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  input  logic [AXI4_ID_WIDTH-1:0] m_rid,
  input  logic [DATA_WIDTH-1:0]    m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rlast,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  // status
  output logic                     busy,
  output logic                     owner,
  output logic                     len_err
);

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;

  state_t     state, state_nxt;
  logic       rr;
  logic [7:0] beat_cnt, beat_len;
  logic       req0, req1, win, win_aw;
  logic       own_awvalid, own_wvalid, own_wlast, own_bready, own_arvalid, own_rready;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign req0   = s0_awvalid | s0_arvalid;
  assign req1   = s1_awvalid | s1_arvalid;
  assign win    = (req0 & req1) ? rr : req1;
  assign win_aw = win ? s1_awvalid : s0_awvalid;

  // Owner-selected request fields; idle-channel values are don't-care.
  assign m_awid      = owner ? s1_awid    : s0_awid;
  assign m_awaddr    = owner ? s1_awaddr  : s0_awaddr;
  assign m_awlen     = owner ? s1_awlen   : s0_awlen;
  assign m_awsize    = owner ? s1_awsize  : s0_awsize;
  assign m_awburst   = owner ? s1_awburst : s0_awburst;
  assign m_wdata     = owner ? s1_wdata   : s0_wdata;
  assign m_wstrb     = owner ? s1_wstrb   : s0_wstrb;
  assign m_arid      = owner ? s1_arid    : s0_arid;
  assign m_araddr    = owner ? s1_araddr  : s0_araddr;
  assign m_arlen     = owner ? s1_arlen   : s0_arlen;
  assign m_arsize    = owner ? s1_arsize  : s0_arsize;
  assign m_arburst   = owner ? s1_arburst : s0_arburst;
  assign own_awvalid = owner ? s1_awvalid : s0_awvalid;
  assign own_wvalid  = owner ? s1_wvalid  : s0_wvalid;
  assign own_wlast   = owner ? s1_wlast   : s0_wlast;
  assign own_bready  = owner ? s1_bready  : s0_bready;
  assign own_arvalid = owner ? s1_arvalid : s0_arvalid;
  assign own_rready  = owner ? s1_rready  : s0_rready;

  assign s0_bid   = m_bid;
  assign s0_bresp = m_bresp;
  assign s1_bid   = m_bid;
  assign s1_bresp = m_bresp;
  assign s0_rid   = m_rid;
  assign s0_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rid   = m_rid;
  assign s1_rdata = m_rdata;
  assign s1_rresp = m_rresp;
  assign s1_rlast = m_rlast;

  assign m_wlast = (beat_cnt == beat_len);
  assign busy    = (state != IDLE);

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;
  assign b_hs  = m_bvalid & m_bready;
  assign ar_hs = m_arvalid & m_arready;
  assign r_hs  = m_rvalid & m_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr       <= 1'b0;
      owner    <= 1'b0;
      beat_cnt <= '0;
      beat_len <= '0;
      len_err  <= 1'b0;
    end else begin
      if (state == IDLE && (req0 | req1)) owner <= win;
      if (aw_hs) begin
        beat_cnt <= '0;
        beat_len <= m_awlen;
      end else if (w_hs && !m_wlast) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (w_hs && (own_wlast != m_wlast)) len_err <= 1'b1;
      // handshakes are gated by state, so these only fire on the final response
      if (b_hs || (r_hs && m_rlast)) rr <= ~owner;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req0 | req1) state_nxt = win_aw ? WADDR : RADDR;
      WADDR:   if (aw_hs) state_nxt = WDATA;
      WDATA:   if (w_hs && m_wlast) state_nxt = WRESP;
      WRESP:   if (b_hs) state_nxt = IDLE;
      RADDR:   if (ar_hs) state_nxt = RDATA;
      RDATA:   if (r_hs && m_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_awready = 1'b0;
    s1_awready = 1'b0;
    s0_wready  = 1'b0;
    s1_wready  = 1'b0;
    s0_bvalid  = 1'b0;
    s1_bvalid  = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    unique case (state)
      WADDR: begin
        m_awvalid  = own_awvalid;
        s0_awready = ~owner & m_awready;
        s1_awready =  owner & m_awready;
      end
      WDATA: begin
        m_wvalid  = own_wvalid;
        s0_wready = ~owner & m_wready;
        s1_wready =  owner & m_wready;
      end
      WRESP: begin
        m_bready  = own_bready;
        s0_bvalid = ~owner & m_bvalid;
        s1_bvalid =  owner & m_bvalid;
      end
      RADDR: begin
        m_arvalid  = own_arvalid;
        s0_arready = ~owner & m_arready;
        s1_arready =  owner & m_arready;
      end
      RDATA: begin
        m_rready  = own_rready;
        s0_rvalid = ~owner & m_rvalid;
        s1_rvalid =  owner & m_rvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dram_axi_arbiter.sv
// Directed bench for dram_axi_arbiter: the downstream controller is driven by hand,
// inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_dram_axi_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  s0_awid, s1_awid, s0_arid, s1_arid;
  logic [31:0] s0_awaddr, s1_awaddr, s0_araddr, s1_araddr;
  logic [7:0]  s0_awlen, s1_awlen, s0_arlen, s1_arlen;
  logic [2:0]  s0_awsize, s1_awsize, s0_arsize, s1_arsize;
  logic [1:0]  s0_awburst, s1_awburst, s0_arburst, s1_arburst;
  logic        s0_awvalid, s1_awvalid, s0_arvalid, s1_arvalid;
  logic        s0_awready, s1_awready, s0_arready, s1_arready;
  logic [31:0] s0_wdata, s1_wdata;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic        s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
  logic [3:0]  s0_bid, s1_bid, s0_rid, s1_rid;
  logic [1:0]  s0_bresp, s1_bresp, s0_rresp, s1_rresp;
  logic        s0_bvalid, s1_bvalid, s0_bready, s1_bready;
  logic [31:0] s0_rdata, s1_rdata;
  logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;

  logic [3:0]  m_awid, m_arid, m_bid, m_rid;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize;
  logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic        m_bvalid, m_bready, m_arvalid, m_arready;
  logic        m_rlast, m_rvalid, m_rready;
  logic        busy, owner, len_err;

  int n_cmp = 0;
  int n_err = 0;

  dram_axi_arbiter #(.AXI4_ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
    .s0_awburst(s0_awburst), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid),
    .s0_wready(s0_wready), .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid),
    .s0_bready(s0_bready), .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
    .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid),
    .s0_arready(s0_arready), .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
    .s1_awburst(s1_awburst), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid),
    .s1_wready(s1_wready), .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid),
    .s1_bready(s1_bready), .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
    .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid),
    .s1_arready(s1_arready), .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy), .owner(owner), .len_err(len_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_aw(input bit p, input logic v, input logic [31:0] a, input logic [7:0] l);
    if (p) begin s1_awvalid = v; s1_awaddr = a; s1_awlen = l; end
    else   begin s0_awvalid = v; s0_awaddr = a; s0_awlen = l; end
  endtask

  task automatic set_w(input bit p, input logic v, input logic [31:0] d, input logic last);
    if (p) begin s1_wvalid = v; s1_wdata = d; s1_wlast = last; end
    else   begin s0_wvalid = v; s0_wdata = d; s0_wlast = last; end
  endtask

  task automatic set_ar(input bit p, input logic v, input logic [31:0] a, input logic [7:0] l);
    if (p) begin s1_arvalid = v; s1_araddr = a; s1_arlen = l; end
    else   begin s0_arvalid = v; s0_araddr = a; s0_arlen = l; end
  endtask

  task automatic set_br(input bit p, input logic b, input logic r);
    if (p) begin s1_bready = b; s1_rready = r; end
    else   begin s0_bready = b; s0_rready = r; end
  endtask

  // Single-beat write; entered on the falling edge right after the grant edge.
  task automatic wr1(input bit p, input logic [31:0] addr, input logic [31:0] data);
    #1;
    chk("wr_busy", busy, 1);
    chk("wr_owner", owner, p);
    chk("wr_m_awvalid", m_awvalid, 1);
    chk("wr_m_awaddr", m_awaddr, addr);
    chk("wr_m_arvalid", m_arvalid, 0);
    chk("wr_awready_own", p ? s1_awready : s0_awready, 1);
    chk("wr_awready_other", p ? s0_awready : s1_awready, 0);
    @(negedge clk);
    set_aw(p, 0, 0, 0);
    set_w(p, 1, data, 1);
    #1;
    chk("wr_m_wvalid", m_wvalid, 1);
    chk("wr_m_wdata", m_wdata, data);
    chk("wr_m_wlast", m_wlast, 1);
    chk("wr_wready_own", p ? s1_wready : s0_wready, 1);
    chk("wr_wready_other", p ? s0_wready : s1_wready, 0);
    @(negedge clk);
    set_w(p, 0, 0, 0);
    m_bvalid = 1; m_bresp = 2'b00;
    set_br(p, 1, 0);
    #1;
    chk("wr_bvalid_own", p ? s1_bvalid : s0_bvalid, 1);
    chk("wr_bresp_own", p ? s1_bresp : s0_bresp, 0);
    chk("wr_bvalid_other", p ? s0_bvalid : s1_bvalid, 0);
    chk("wr_m_bready", m_bready, 1);
    @(negedge clk);
    m_bvalid = 0;
    set_br(p, 0, 0);
    #1;
    chk("wr_idle_busy", busy, 0);
  endtask

  // Single-beat read; entered on the falling edge right after the grant edge.
  task automatic rd1(input bit p, input logic [31:0] addr, input logic [31:0] data);
    #1;
    chk("rd_busy", busy, 1);
    chk("rd_owner", owner, p);
    chk("rd_m_arvalid", m_arvalid, 1);
    chk("rd_m_araddr", m_araddr, addr);
    chk("rd_m_awvalid", m_awvalid, 0);
    chk("rd_arready_own", p ? s1_arready : s0_arready, 1);
    chk("rd_arready_other", p ? s0_arready : s1_arready, 0);
    @(negedge clk);
    set_ar(p, 0, 0, 0);
    m_rvalid = 1; m_rdata = data; m_rlast = 1;
    set_br(p, 0, 1);
    #1;
    chk("rd_rvalid_own", p ? s1_rvalid : s0_rvalid, 1);
    chk("rd_rdata_own", p ? s1_rdata : s0_rdata, data);
    chk("rd_rlast_own", p ? s1_rlast : s0_rlast, 1);
    chk("rd_rvalid_other", p ? s0_rvalid : s1_rvalid, 0);
    chk("rd_m_rready", m_rready, 1);
    @(negedge clk);
    m_rvalid = 0; m_rlast = 0;
    set_br(p, 0, 0);
    #1;
    chk("rd_idle_busy", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0;
    {s0_awid, s1_awid, s0_arid, s1_arid} = '0;
    {s0_awsize, s1_awsize, s0_arsize, s1_arsize} = '0;
    {s0_awburst, s1_awburst, s0_arburst, s1_arburst} = '0;
    s0_wstrb = '1; s1_wstrb = '1;
    set_aw(0, 0, 0, 0); set_aw(1, 0, 0, 0);
    set_w(0, 0, 0, 0);  set_w(1, 0, 0, 0);
    set_ar(0, 0, 0, 0); set_ar(1, 0, 0, 0);
    set_br(0, 0, 0);    set_br(1, 0, 0);
    m_awready = 1; m_wready = 1; m_arready = 1;
    m_bid = '0; m_bresp = '0; m_bvalid = 0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_s0_awready", s0_awready, 0);
    chk("rst_s1_arready", s1_arready, 0);
    chk("rst_m_rready", m_rready, 0);

    // single write from s0
    @(negedge clk); rst_n = 1;
    @(negedge clk); set_aw(0, 1, 32'h100, 0);
    @(negedge clk); wr1(0, 32'h100, 32'hDEADBEEF);

    // both ports write from reset release, then a third concurrent pair
    rst_n = 0;
    set_aw(0, 1, 32'h200, 0); set_aw(1, 1, 32'h300, 0);
    #1;
    chk("rst_hold_m_awvalid", m_awvalid, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk); wr1(0, 32'h200, 32'h0000_2222);
    @(negedge clk); wr1(1, 32'h300, 32'h0000_3333);
    set_aw(0, 1, 32'h400, 0); set_aw(1, 1, 32'h500, 0);
    @(negedge clk); wr1(0, 32'h400, 32'h0000_4444);
    set_aw(1, 0, 0, 0);

    // s1 four-beat read with a stall on beat 2
    set_ar(1, 1, 32'h1000, 3);
    @(negedge clk);
    #1;
    chk("r4_owner", owner, 1);
    chk("r4_m_arvalid", m_arvalid, 1);
    chk("r4_m_araddr", m_araddr, 32'h1000);
    chk("r4_m_arlen", m_arlen, 3);
    chk("r4_s0_arready", s0_arready, 0);
    @(negedge clk);
    set_ar(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1; m_rdata = 32'hA0 + 32'(i); m_rlast = (i == 3);
      if (i == 2) begin
        s1_rready = 0;
        #1;
        chk("r4_stall_m_rready", m_rready, 0);
        chk("r4_stall_rvalid", s1_rvalid, 1);
        @(negedge clk);
      end
      s1_rready = 1;
      #1;
      chk("r4_rvalid", s1_rvalid, 1);
      chk("r4_rdata", s1_rdata, 32'hA0 + 32'(i));
      chk("r4_rlast", s1_rlast, (i == 3));
      chk("r4_s0_rvalid", s0_rvalid, 0);
      @(negedge clk);
    end
    m_rvalid = 0; m_rlast = 0; s1_rready = 0;
    #1;
    chk("r4_idle_busy", busy, 0);

    // s0 two-beat write with upstream wlast on the wrong beat
    set_aw(0, 1, 32'h600, 1);
    @(negedge clk);
    #1;
    chk("le_m_awlen", m_awlen, 1);
    chk("le_owner", owner, 0);
    @(negedge clk);
    set_aw(0, 0, 0, 0);
    set_w(0, 1, 32'h11, 1);
    #1;
    chk("le_beat0_wlast", m_wlast, 0);
    chk("le_beat0_len_err", len_err, 0);
    @(negedge clk);
    set_w(0, 1, 32'h22, 0);
    #1;
    chk("le_beat1_wlast", m_wlast, 1);
    chk("le_beat1_wdata", m_wdata, 32'h22);
    chk("le_beat1_len_err", len_err, 1);
    @(negedge clk);
    set_w(0, 0, 0, 0);
    m_bvalid = 1; set_br(0, 1, 0);
    #1;
    chk("le_bvalid", s0_bvalid, 1);
    @(negedge clk);
    m_bvalid = 0; set_br(0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("le_sticky", len_err, 1);
    chk("le_idle_busy", busy, 0);

    // s0 write+read vs s1 read: s0 write, s1 read, s0 read
    rst_n = 0;
    #1;
    chk("rst2_len_err", len_err, 0);
    chk("rst2_owner", owner, 0);
    set_aw(0, 1, 32'h700, 0); set_ar(0, 1, 32'h800, 0); set_ar(1, 1, 32'h900, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk); wr1(0, 32'h700, 32'h0000_7777);
    @(negedge clk); rd1(1, 32'h900, 32'h0000_9999);
    @(negedge clk); rd1(0, 32'h800, 32'h0000_8888);

    // reset during beat 2 of a 4-beat write
    set_aw(0, 1, 32'hA00, 3);
    @(negedge clk);
    @(negedge clk);
    set_aw(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      set_w(0, 1, 32'hB0 + 32'(i), 0);
      @(negedge clk);
    end
    set_w(0, 1, 32'hB2, 0);
    #1;
    chk("mr_pre_m_wvalid", m_wvalid, 1);
    chk("mr_pre_wready", s0_wready, 1);
    chk("mr_pre_m_wlast", m_wlast, 0);
    #1 rst_n = 0;
    #1;
    chk("mr_m_wvalid", m_wvalid, 0);
    chk("mr_s0_wready", s0_wready, 0);
    chk("mr_busy", busy, 0);
    chk("mr_m_bready", m_bready, 0);
    chk("mr_m_awvalid", m_awvalid, 0);
    set_w(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    set_ar(1, 1, 32'hC00, 0);
    @(negedge clk); rd1(1, 32'hC00, 32'h0000_CCCC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
